router_fifo: RTL and testbench

//   One of three per-port output FIFOs of the router. Sits directly downstream of the

---
 rtl/router_fifo.sv | 95 +++++++++
 tb/tb_router_fifo.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : router_fifo
// Brief   : Per-port router output FIFO with header tag and read-side packet
//           length tracking so the destination drains exactly one packet.
// Revision: 1.0 - initial release
// ============================================================================
module router_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] data_out
);

    localparam int               c_CNT_W   = 7;
    localparam logic [ADDR_W:0]  c_PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = {{(c_CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH:0]         r_mem [DEPTH];
    logic [ADDR_W:0]        r_wr_ptr;
    logic [ADDR_W:0]        r_rd_ptr;
    logic [c_CNT_W-1:0]     r_pkt_cnt;
    logic [WIDTH-1:0]       r_data_out;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_clr;
    logic                   w_wr;
    logic                   w_rd;
    logic [WIDTH:0]         w_rd_word;
    logic [c_CNT_W-1:0]     w_hdr_cnt;

    // The extra pointer bit separates full (bits differ) from empty (bits equal).
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                       (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_clr     = reset || soft_reset;
    assign w_wr      = write_enb && !w_full;
    assign w_rd      = read_enb && !w_empty;
    assign w_rd_word = r_mem[r_rd_ptr[ADDR_W-1:0]];
    // Header length field plus one for the trailing parity byte.
    assign w_hdr_cnt = {1'b0, w_rd_word[7:2]} + c_CNT_ONE;

    always_ff @(posedge clock) begin
        if (w_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i][WIDTH] <= 1'b0;
            end
        end else if (w_wr) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clock) begin
        if (w_clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pkt_cnt  <= '0;
            r_data_out <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
                r_data_out <= w_rd_word[WIDTH-1:0];
                if (w_rd_word[WIDTH]) begin
                    r_pkt_cnt <= w_hdr_cnt;
                end else if (r_pkt_cnt != '0) begin
                    r_pkt_cnt <= r_pkt_cnt - c_CNT_ONE;
                end
            end else if (r_pkt_cnt == '0) begin
                // Between packets the output idles at zero.
                r_data_out <= '0;
            end
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_router_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_router_fifo
// Brief   : Directed self-checking bench for router_fifo.
// Revision: 1.0 - initial release
// ============================================================================
module tb_router_fifo;

    logic       clock;
    logic       reset;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       full;
    logic       empty;
    logic [7:0] data_out;

    int tests_run = 0;
    int tests_failed = 0;

    router_fifo #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .full       (full),
        .empty      (empty),
        .data_out   (data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance past one rising edge; inputs set before the call take effect there.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [7:0] d, input logic tag);
        write_enb = 1'b1;
        data_in   = d;
        lfd_state = tag;
        tick();
        write_enb = 1'b0;
        lfd_state = 1'b0;
    endtask

    task automatic do_read();
        read_enb = 1'b1;
        tick();
        read_enb = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tests_run++;
        if (empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_empty: got %b expected 1", empty);
        end
        tests_run++;
        if (full !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_full: got %b expected 0", full);
        end
        tests_run++;
        if (data_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_data_out: got %h expected 00", data_out);
        end
    endtask

    task automatic test_packet();
        logic [7:0] pkt [5];
        pkt[0] = 8'h0D; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h44;
        for (int i = 0; i < 5; i++) do_write(pkt[i], (i == 0));
        for (int i = 0; i < 5; i++) begin
            do_read();
            tests_run++;
            if (data_out !== pkt[i]) begin
                tests_failed++;
                $display("FAIL packet_byte%0d: got %h expected %h", i, data_out, pkt[i]);
            end
        end
        tests_run++;
        if (empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL packet_empty: got %b expected 1", empty);
        end
        tick();
        tests_run++;
        if (data_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL packet_idle_zero: got %h expected 00", data_out);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) do_write(8'hA0 + 8'(i), 1'b0);
        tests_run++;
        if (full !== 1'b1 || empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_full: got full=%b empty=%b expected full=1 empty=0", full, empty);
        end
        do_write(8'hFF, 1'b0);
        tests_run++;
        if (full !== 1'b1) begin
            tests_failed++;
            $display("FAIL fill_overwrite_full: got %b expected 1", full);
        end
        for (int i = 0; i < 16; i++) begin
            do_read();
            tests_run++;
            if (data_out !== 8'hA0 + 8'(i)) begin
                tests_failed++;
                $display("FAIL fill_read%0d: got %h expected %h", i, data_out, 8'hA0 + 8'(i));
            end
        end
        tests_run++;
        if (empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL fill_drained_empty: got %b expected 1", empty);
        end
        do_write(8'h5A, 1'b0);
        do_read();
        tests_run++;
        if (data_out !== 8'h5A) begin
            tests_failed++;
            $display("FAIL fill_roundtrip: got %h expected 5a", data_out);
        end
        tick();
    endtask

    task automatic test_same_cycle();
        // Empty: only the write lands.
        write_enb = 1'b1; read_enb = 1'b1; data_in = 8'h77;
        tick();
        write_enb = 1'b0; read_enb = 1'b0;
        tests_run++;
        if (empty !== 1'b0 || data_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL rw_at_empty: got empty=%b data_out=%h expected empty=0 data_out=00", empty, data_out);
        end
        do_read();
        tests_run++;
        if (data_out !== 8'h77) begin
            tests_failed++;
            $display("FAIL rw_at_empty_data: got %h expected 77", data_out);
        end
        // Count 8: one out, one in, occupancy unchanged.
        for (int i = 0; i < 8; i++) do_write(8'hB0 + 8'(i), 1'b0);
        write_enb = 1'b1; read_enb = 1'b1; data_in = 8'hC0;
        tick();
        write_enb = 1'b0; read_enb = 1'b0;
        tests_run++;
        if (data_out !== 8'hB0) begin
            tests_failed++;
            $display("FAIL rw_mid_data: got %h expected b0", data_out);
        end
        for (int i = 0; i < 7; i++) do_read();
        tests_run++;
        if (data_out !== 8'hB7 || empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL rw_mid_count: got data_out=%h empty=%b expected b7 0", data_out, empty);
        end
        do_read();
        tests_run++;
        if (data_out !== 8'hC0 || empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL rw_mid_last: got data_out=%h empty=%b expected c0 1", data_out, empty);
        end
        // Full: read happens, write dropped.
        for (int i = 0; i < 16; i++) do_write(8'hD0 + 8'(i), 1'b0);
        write_enb = 1'b1; read_enb = 1'b1; data_in = 8'hE0;
        tick();
        write_enb = 1'b0; read_enb = 1'b0;
        tests_run++;
        if (full !== 1'b0 || data_out !== 8'hD0) begin
            tests_failed++;
            $display("FAIL rw_at_full: got full=%b data_out=%h expected full=0 data_out=d0", full, data_out);
        end
        for (int i = 0; i < 15; i++) do_read();
        tests_run++;
        if (data_out !== 8'hDF || empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL rw_full_drop: got data_out=%h empty=%b expected df 1", data_out, empty);
        end
        tick();
    endtask

    task automatic test_soft_reset();
        logic [7:0] pkt [4];
        do_write(8'h0D, 1'b1);
        do_write(8'h11, 1'b0);
        do_write(8'h22, 1'b0);
        do_write(8'h33, 1'b0);
        do_write(8'h44, 1'b0);
        do_write(8'h55, 1'b0);
        do_read();
        do_read();
        tests_run++;
        if (data_out !== 8'h11) begin
            tests_failed++;
            $display("FAIL soft_pre_data: got %h expected 11", data_out);
        end
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        tests_run++;
        if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL soft_reset_state: got empty=%b full=%b data_out=%h expected 1 0 00", empty, full, data_out);
        end
        pkt[0] = 8'h08; pkt[1] = 8'h66; pkt[2] = 8'h77; pkt[3] = 8'h88;
        for (int i = 0; i < 4; i++) do_write(pkt[i], (i == 0));
        for (int i = 0; i < 4; i++) begin
            do_read();
            tests_run++;
            if (data_out !== pkt[i]) begin
                tests_failed++;
                $display("FAIL soft_pkt_byte%0d: got %h expected %h", i, data_out, pkt[i]);
            end
        end
        tick();
        tests_run++;
        if (data_out !== 8'h00 || empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL soft_pkt_idle: got data_out=%h empty=%b expected 00 1", data_out, empty);
        end
    endtask

    task automatic test_empty_read_and_len0();
        // Header len 2 keeps the packet open after two reads.
        do_write(8'h08, 1'b1);
        do_write(8'h31, 1'b0);
        do_read();
        do_read();
        do_read();
        tests_run++;
        if (data_out !== 8'h31 || empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL empty_read_hold: got data_out=%h empty=%b expected 31 1", data_out, empty);
        end
        do_write(8'h32, 1'b0);
        do_read();
        tests_run++;
        if (data_out !== 8'h32) begin
            tests_failed++;
            $display("FAIL empty_read_ptr: got %h expected 32", data_out);
        end
        do_write(8'h33, 1'b0);
        do_read();
        tick();
        tests_run++;
        if (data_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL empty_read_pkt_end: got %h expected 00", data_out);
        end
        // Zero-length header: only parity follows.
        do_write(8'h03, 1'b1);
        do_write(8'h9C, 1'b0);
        do_read();
        tests_run++;
        if (data_out !== 8'h03) begin
            tests_failed++;
            $display("FAIL len0_header: got %h expected 03", data_out);
        end
        do_read();
        tests_run++;
        if (data_out !== 8'h9C) begin
            tests_failed++;
            $display("FAIL len0_parity: got %h expected 9c", data_out);
        end
        tick();
        tests_run++;
        if (data_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL len0_idle: got %h expected 00", data_out);
        end
    endtask

    initial begin
        reset      = 1'b0;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;
        test_reset();
        test_packet();
        test_fill();
        test_same_cycle();
        test_soft_reset();
        test_empty_read_and_len0();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
